// File: rtl/t5_dctl.sv
// t5 data-bus sequencer: one classic bus cycle per access,
// pipeline stall via sena, load alignment and trap pulses.
module t5_dctl #(
    parameter int TOUT = 16
) (
    input  logic        sclk,
    input  logic        srst,
    input  logic [1:0]  xstb,
    input  logic        xwre,
    input  logic [3:0]  xsel,
    input  logic [14:12] mfn3,
    input  logic        dwb_ack,
    input  logic [31:0] dwb_dti,
    output logic        dwb_cyc,
    output logic        dwb_stb,
    output logic        sena,
    output logic [31:0] mdat,
    output logic [1:0]  mtrp
);

    localparam int TW = (TOUT < 1) ? 1 : $clog2(TOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'((TOUT < 1) ? 0 : TOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          req_ok;
    logic          req_mis;
    logic          tout_hit;
    logic          sx;
    logic [31:0]   ld;

    assign req_ok   = xstb[1] & ~xstb[0];
    assign req_mis  = xstb[1] & xstb[0];
    assign tout_hit = (TOUT != 0) && (timer == TLAST);
    assign sx       = ~mfn3[14];

    assign dwb_cyc = (state == BUSY);
    assign dwb_stb = (state == BUSY);

    always_comb begin
        ld = dwb_dti;
        unique case (xsel)
            4'h1:    ld = {{24{sx & dwb_dti[7]}},  dwb_dti[7:0]};
            4'h2:    ld = {{24{sx & dwb_dti[15]}}, dwb_dti[15:8]};
            4'h4:    ld = {{24{sx & dwb_dti[23]}}, dwb_dti[23:16]};
            4'h8:    ld = {{24{sx & dwb_dti[31]}}, dwb_dti[31:24]};
            4'h3:    ld = {{16{sx & dwb_dti[15]}}, dwb_dti[15:0]};
            4'hC:    ld = {{16{sx & dwb_dti[31]}}, dwb_dti[31:16]};
            default: ld = dwb_dti;
        endcase
    end

    always_comb begin
        sena = 1'b1;
        unique case (state)
            IDLE:    sena = ~req_ok;
            BUSY:    sena = 1'b0;
            default: sena = 1'b1;
        endcase
    end

    // Ack is tested before the terminal count so it wins a tie.
    always_ff @(posedge sclk or negedge srst) begin
        if (!srst) begin
            state <= IDLE;
            timer <= '0;
            mdat  <= '0;
            mtrp  <= '0;
        end else begin
            mtrp <= '0;
            unique case (state)
                IDLE: begin
                    if (req_ok) begin
                        state <= BUSY;
                        timer <= '0;
                    end else if (req_mis) begin
                        mtrp <= 2'b01;
                    end
                end
                BUSY: begin
                    if (dwb_ack) begin
                        state <= DONE;
                        if (!xwre)
                            mdat <= ld;
                    end else if (tout_hit) begin
                        state <= DONE;
                        mtrp  <= 2'b10;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t5_dctl.sv
// Scoreboard bench for t5_dctl: random accesses against a
// lane/extension reference model, checked at each completion.
module tb_t5_dctl;

    localparam int TOUT = 16;

    logic        sclk = 1'b0;
    logic        srst;
    logic [1:0]  xstb;
    logic        xwre;
    logic [3:0]  xsel;
    logic [2:0]  mfn3;
    logic        dwb_ack;
    logic [31:0] dwb_dti;
    logic        dwb_cyc;
    logic        dwb_stb;
    logic        sena;
    logic [31:0] mdat;
    logic [1:0]  mtrp;

    t5_dctl #(.TOUT(TOUT)) dut (
        .sclk    (sclk),
        .srst    (srst),
        .xstb    (xstb),
        .xwre    (xwre),
        .xsel    (xsel),
        .mfn3    (mfn3),
        .dwb_ack (dwb_ack),
        .dwb_dti (dwb_dti),
        .dwb_cyc (dwb_cyc),
        .dwb_stb (dwb_stb),
        .sena    (sena),
        .mdat    (mdat),
        .mtrp    (mtrp)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [31:0] mdat;
        logic [1:0]  trp;
        int          nstb;
        int          nlow;
    } exp_t;

    exp_t        q[$];
    int          errs = 0;
    int          checks = 0;
    logic [31:0] mref = '0;
    int          nstb = 0;
    int          nlow = 0;
    bit          prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [3:0] sel,
                                             input logic uns,
                                             input logic [31:0] d);
        int          lo = 0;
        int          n;
        logic [31:0] v;
        for (int i = 3; i >= 0; i--)
            if (sel[i]) lo = i;
        n = $countones(sel);
        v = d >> (8 * lo);
        if (n == 1)
            return uns ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        if (n == 2)
            return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        return d;
    endfunction

    // waits < 0 means the bus never acknowledges.
    task automatic access(input logic [1:0] stb, input logic wre,
                          input logic [3:0] sel, input logic [2:0] fn3,
                          input logic [31:0] dti, input int waits);
        exp_t e;
        int   nb;
        bit   to;
        xstb = stb;
        xwre = wre;
        xsel = sel;
        mfn3 = fn3;
        dwb_ack = 1'($urandom_range(0, 1));
        dwb_dti = $urandom;
        if (stb == 2'b11) begin
            e = '{mref, 2'b01, 0, 0};
            q.push_back(e);
            @(posedge sclk); #1;
            xstb = 2'b00;
            dwb_ack = 1'b0;
            return;
        end
        to = (waits < 0) || (waits >= TOUT);
        nb = to ? TOUT : waits + 1;
        if (!wre && !to)
            mref = ref_load(sel, fn3[2], dti);
        e = '{mref, to ? 2'b10 : 2'b00, nb, nb + 1};
        q.push_back(e);
        @(posedge sclk); #1;
        for (int k = 1; k <= nb; k++) begin
            dwb_ack = !to && (k == nb);
            dwb_dti = dwb_ack ? dti : $urandom;
            @(posedge sclk); #1;
        end
        dwb_ack = 1'($urandom_range(0, 1));
        dwb_dti = $urandom;
        @(posedge sclk); #1;
        xstb = 2'b00;
        dwb_ack = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        bit   ev;
        forever begin
            @(negedge sclk);
            if (!srst) begin
                prev = 1'b0;
                nstb = 0;
                nlow = 0;
            end else begin
                ev = (prev && !dwb_cyc) || mtrp[0];
                if (ev) begin
                    if (q.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL unexpected_event: mtrp %b with empty queue at %0t",
                                 mtrp, $time);
                    end else begin
                        e = q.pop_front();
                        check("mdat", mdat, e.mdat);
                        check("mtrp", 32'(mtrp), 32'(e.trp));
                        check("stb_cycles", 32'(nstb), 32'(e.nstb));
                        check("sena_low", 32'(nlow), 32'(e.nlow));
                    end
                    nstb = 0;
                    nlow = 0;
                end else begin
                    check("mtrp_quiet", 32'(mtrp), 32'h0);
                end
                if (dwb_stb) nstb++;
                if (!sena) nlow++;
                prev = dwb_cyc;
            end
        end
    end

    logic [3:0] sels [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    initial begin : stim
        int r;
        int w;
        srst = 1'b0;
        xstb = 2'b00;
        xwre = 1'b0;
        xsel = 4'h0;
        mfn3 = 3'b000;
        dwb_ack = 1'b0;
        dwb_dti = '0;
        #3;
        check("rst_mdat", mdat, 32'h0);
        check("rst_mtrp", 32'(mtrp), 32'h0);
        check("rst_cyc", 32'(dwb_cyc), 32'h0);
        check("rst_stb", 32'(dwb_stb), 32'h0);
        check("rst_sena", 32'(sena), 32'h1);
        repeat (2) @(posedge sclk);
        #1 srst = 1'b1;
        @(posedge sclk); #1;

        access(2'b10, 1'b0, 4'h4, 3'b000, 32'h0080_0000, 0);
        check("sb_load", mdat, 32'hFFFF_FF80);
        access(2'b10, 1'b0, 4'hC, 3'b101, 32'h8001_1234, 3);
        check("uh_load", mdat, 32'h0000_8001);
        access(2'b10, 1'b1, 4'hF, 3'b010, 32'h1357_9BDF, 1);
        check("store_keep", mdat, 32'h0000_8001);
        access(2'b11, 1'b0, 4'hF, 3'b010, 32'h0, 0);
        access(2'b10, 1'b0, 4'hF, 3'b010, 32'hDEAD_BEEF, -1);
        check("tout_keep", mdat, 32'h0000_8001);
        access(2'b10, 1'b0, 4'hF, 3'b010, 32'hCAFE_F00D, TOUT - 1);
        check("ack_at_tc", mdat, 32'hCAFE_F00D);

        xstb = 2'b10;
        xwre = 1'b0;
        xsel = 4'hF;
        mfn3 = 3'b010;
        dwb_ack = 1'b0;
        @(posedge sclk); #1;
        @(posedge sclk); #1;
        check("busy2_cyc", 32'(dwb_cyc), 32'h1);
        srst = 1'b0;
        #1;
        check("arst_cyc", 32'(dwb_cyc), 32'h0);
        check("arst_stb", 32'(dwb_stb), 32'h0);
        xstb = 2'b00;
        mref = '0;
        repeat (2) @(posedge sclk);
        #1 srst = 1'b1;
        @(negedge sclk);
        check("post_rst_sena", 32'(sena), 32'h1);
        check("post_rst_mdat", mdat, 32'h0);
        check("post_rst_cyc", 32'(dwb_cyc), 32'h0);
        @(posedge sclk); #1;

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                access(2'b11, 1'($urandom_range(0, 1)), sels[$urandom_range(0, 6)],
                       3'($urandom_range(0, 7)), $urandom, 0);
            end else begin
                w = (r == 1) ? -1 : $urandom_range(0, 4);
                access(2'b10, 1'($urandom_range(0, 3) == 0),
                       sels[$urandom_range(0, 6)],
                       3'($urandom_range(0, 7)), $urandom, w);
            end
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) begin
                    @(posedge sclk); #1;
                end
        end

        repeat (4) @(posedge sclk);
        check("queue_empty", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
